// File: rtl/ysyx_22050710_mem_responder.sv
// ysyx_22050710_mem_responder: single-outstanding valid/ready SRAM responder with programmable latency; define YSYX_22050710_MEM_JITTER_EN for LFSR latency jitter
module ysyx_22050710_mem_responder #(
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [63:0] i_req_addr,
  input  logic        i_req_wen,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wmask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err
);
  localparam logic [63:0] SIZE = 64'd1 << (DEPTH_LOG2 + 3);
  localparam logic [4:0]  CNT0 = 5'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_state_next;
  logic [4:0] r_cnt, w_cnt_next, w_cnt_load;
  logic [63:0] r_addr, r_wdata, r_rdata, w_addr, w_wdata, w_off;
  logic [7:0] r_wmask, w_wmask;
  logic r_wen, r_err, w_wen, w_accept, w_commit, w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [63:0] r_mem [2**DEPTH_LOG2];
`ifdef YSYX_22050710_MEM_JITTER_EN
  logic [7:0] r_lfsr;
  // free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge i_clk)
    r_lfsr <= i_rst ? 8'hA5 : {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_cnt_load = CNT0 + {3'b000, r_lfsr[1:0]};
`else
  assign w_cnt_load = CNT0;
`endif
  assign o_req_ready = r_state == IDLE;
  assign o_rsp_valid = r_state == RESP;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign w_accept    = r_state == IDLE && i_req_valid && !i_rst;
  assign w_addr      = r_state == IDLE ? i_req_addr  : r_addr;
  assign w_wdata     = r_state == IDLE ? i_req_wdata : r_wdata;
  assign w_wmask     = r_state == IDLE ? i_req_wmask : r_wmask;
  assign w_wen       = r_state == IDLE ? i_req_wen   : r_wen;
  assign w_off       = w_addr - BASE;
  assign w_in_range  = w_addr >= BASE && w_off < SIZE;
  assign w_idx       = w_off[DEPTH_LOG2+2:3];
  assign w_commit    = (w_accept && w_cnt_load == 5'd0) || (!i_rst && r_state == WAIT && r_cnt == 5'd1);
  // next-state and latency counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: if (i_req_valid) begin
        w_cnt_next   = w_cnt_load;
        w_state_next = w_cnt_load == 5'd0 ? RESP : WAIT;
      end
      WAIT: begin
        w_cnt_next   = r_cnt - 5'd1;
        w_state_next = r_cnt == 5'd1 ? RESP : WAIT;
      end
      RESP: w_state_next = i_rsp_ready ? IDLE : RESP;
      default: w_state_next = IDLE;
    endcase
  end
  // state, request latch and response capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_commit) begin
        r_rdata <= (w_in_range && !w_wen) ? r_mem[w_idx] : 64'd0;
        r_err   <= !w_in_range;
      end
    end
    if (w_accept) begin
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
      r_wmask <= i_req_wmask;
      r_wen   <= i_req_wen;
    end
  end
  // byte-masked SRAM write at commit; contents are never reset
  always_ff @(posedge i_clk)
    if (w_commit && w_wen && w_in_range)
      for (int k = 0; k < 8; k++)
        if (w_wmask[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
endmodule

// File: tb/tb_ysyx_22050710_mem_responder.sv
// tb_ysyx_22050710_mem_responder: scoreboard bench for the memory responder
module tb_ysyx_22050710_mem_responder;
  localparam int          L    = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h8_0000;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wen = 0, rsp_ready = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [7:0] req_wmask = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic req_valid1 = 0, req_ready1, rsp_valid1, rsp_err1;
  logic rsp_ready1 = 1;
  logic [63:0] rsp_rdata1;
  logic [63:0] model [longint];
  logic [64:0] sb [$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ysyx_22050710_mem_responder #(.DEPTH_LOG2(16), .BASE(BASE), .LATENCY(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err));
  ysyx_22050710_mem_responder #(.DEPTH_LOG2(8), .BASE(BASE), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid1), .o_req_ready(req_ready1),
    .i_req_addr(BASE), .i_req_wen(1'b0), .i_req_wdata(64'd0), .i_req_wmask(8'd0),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1), .o_rsp_rdata(rsp_rdata1), .o_rsp_err(rsp_err1));
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic txn(input string tag, input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [7:0] wm, input int hold);
    logic [64:0] exp, got;
    logic [63:0] old;
    logic in_r;
    longint idx;
    int lat;
    in_r = addr >= BASE && (addr - BASE) < SIZE;
    idx  = longint'((addr - BASE) >> 3);
    old  = model.exists(idx) ? model[idx] : 64'd0;
    sb.push_back({!in_r, (in_r && !wen) ? old : 64'd0});
    if (in_r && wen) begin
      for (int k = 0; k < 8; k++) if (wm[k]) old[8*k +: 8] = wd[8*k +: 8];
      model[idx] = old;
    end
    chk({tag, "_idle_ready"}, {64'd0, req_ready}, 65'd1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm;
    @(posedge clk); #1;
    req_valid = 0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom); req_wen = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
`ifdef YSYX_22050710_MEM_JITTER_EN
    chk({tag, "_latency"}, {64'd0, lat >= L && lat <= L + 3}, 65'd1);
`else
    chk({tag, "_latency"}, 65'(lat), 65'(L));
`endif
    got = {rsp_err, rsp_rdata};
    chk({tag, "_busy_ready"}, {64'd0, req_ready}, 65'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {64'd0, rsp_valid}, 65'd1);
      chk({tag, "_hold_data"}, {rsp_err, rsp_rdata}, got);
      chk({tag, "_hold_ready"}, {64'd0, req_ready}, 65'd0);
    end
    exp = sb.pop_front();
    chk({tag, "_rsp"}, got, exp);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({tag, "_post_valid"}, {64'd0, rsp_valid}, 65'd0);
    chk({tag, "_post_ready"}, {64'd0, req_ready}, 65'd1);
  endtask
  initial begin
    int acc, rv;
    logic [63:0] a, d;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", {64'd0, req_ready}, 65'd1);
    chk("rst_valid", {64'd0, rsp_valid}, 65'd0);
    chk("rst_data", {rsp_err, rsp_rdata}, 65'd0);
    txn("t1_wr", 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
    txn("t1_rd", 0, 64'h8000_0010, 64'h0, 8'h00, 0);
    txn("t2_wr", 1, 64'h8000_0010, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F, 0);
    txn("t2_rd", 0, 64'h8000_0017, 64'h0, 8'h00, 0);
    txn("t3_wr0", 1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    txn("t3_lo", 0, 64'h7FFF_FFF8, 64'h0, 8'h00, 0);
    txn("t3_hi", 0, 64'h8008_0000, 64'h0, 8'h00, 0);
    txn("t3_hiwr", 1, 64'h8008_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0);
    txn("t3_rd0", 0, 64'h8000_0000, 64'h0, 8'h00, 0);
    txn("t3_lastwr", 1, 64'h8007_FFF8, 64'h5A5A_0000_1234_FFFF, 8'hFF, 0);
    txn("t3_lastrd", 0, 64'h8007_FFF8, 64'h0, 8'h00, 0);
    txn("mask0_wr", 1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
    txn("mask0_rd", 0, 64'h8000_0010, 64'h0, 8'h00, 0);
    txn("t4_hold", 0, 64'h8000_0010, 64'h0, 8'h00, 5);
    txn("t5_init", 1, 64'h8000_0020, 64'hCAFE_F00D_0000_1111, 8'hFF, 0);
    req_valid = 1; req_wen = 1; req_addr = 64'h8000_0020; req_wdata = 64'hDEAD; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("t5_ready", {64'd0, req_ready}, 65'd1);
    chk("t5_valid", {64'd0, rsp_valid}, 65'd0);
    chk("t5_data", {rsp_err, rsp_rdata}, 65'd0);
    txn("t5_rd", 0, 64'h8000_0020, 64'h0, 8'h00, 0);
    rst = 1; req_valid = 1; req_wen = 1; req_addr = 64'h8000_0020; req_wdata = 64'hBAD;
    @(posedge clk); #1;
    rst = 0; req_valid = 0;
    chk("rst_vs_req", {64'd0, req_ready}, 65'd1);
    txn("rst_vs_req_rd", 0, 64'h8000_0020, 64'h0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      a = BASE + 64'({$urandom_range(0, 7), 3'b000});
      d = {$urandom, $urandom};
      txn("rnd_wr", 1, a, d, 8'hFF, 0);
      txn("rnd_pwr", 1, a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2));
      txn("rnd_rd", 0, a, 64'h0, 8'h00, 0);
    end
    acc = 0; rv = 0;
    req_valid1 = 1;
    repeat (20) begin
      acc += int'(req_ready1);
      @(posedge clk); #1;
      rv += int'(rsp_valid1);
    end
    req_valid1 = 0;
`ifdef YSYX_22050710_MEM_JITTER_EN
    chk("t6_accepts", {64'd0, acc >= 4 && acc <= 10}, 65'd1);
    chk("t6_rsps", {64'd0, rv >= 4 && rv <= 10}, 65'd1);
`else
    chk("t6_accepts", 65'(acc), 65'd10);
    chk("t6_rsps", 65'(rv), 65'd10);
`endif
    chk("sb_empty", 65'(sb.size()), 65'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
